// File: rtl/seg7_scan_mux_pkg.sv
// rtl/seg7_scan_mux_pkg.sv - glyph table, segment bit order and parameter checks for seg7_scan_mux
package seg7_scan_mux_pkg;

    localparam int SEG_W = 7;

    // Segment bus order, MSB first: {a,b,c,d,e,f,g}
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
    } seg_bits_t;

    localparam logic [SEG_W-1:0] SEG_0   = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_1   = 7'h30;
    localparam logic [SEG_W-1:0] SEG_2   = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_3   = 7'h79;
    localparam logic [SEG_W-1:0] SEG_4   = 7'h33;
    localparam logic [SEG_W-1:0] SEG_5   = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_6   = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_7   = 7'h70;
    localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9   = 7'h7B;
    localparam logic [SEG_W-1:0] SEG_A   = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B   = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_C   = 7'h4E;
    localparam logic [SEG_W-1:0] SEG_D   = 7'h3D;
    localparam logic [SEG_W-1:0] SEG_E   = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_F   = 7'h47;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    // Legal configurations: 2..8 digits, slot of at least 2 cycles, dead time shorter than a slot
    function automatic bit params_ok(input int digits, input int prescale, input int dead);
        return (digits >= 2) && (digits <= 8) && (prescale >= 2) &&
               (dead >= 0) && (dead < prescale);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to 7-segment glyph decoder
module seg7_hex_decode
    import seg7_scan_mux_pkg::*;
(
    input  logic [3:0]       i_nib,
    output logic [SEG_W-1:0] o_seg
);

    // Table lookup of the hex glyph for one nibble
    always_comb begin
        o_seg = SEG_OFF;
        case (i_nib)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - multiplexed 7-segment scanner with double-buffered value and leading-zero blanking
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4,
    parameter int DEAD     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     dig_en,
    output logic [SEG_W-1:0]      seg,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    if (!params_ok(DIGITS, PRESCALE, DEAD)) begin : g_bad_params
        $error("seg7_scan_mux: illegal DIGITS/PRESCALE/DEAD combination");
    end

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_act;
    logic [4*DIGITS-1:0] r_pend;
    logic                r_pend_v;
    logic [DIGITS-1:0]   r_dig_en;
    logic [SEG_W-1:0]    r_seg;
    logic                r_frame_done;

    logic                w_tick;
    logic                w_boundary;
    logic                w_live;
    logic                w_zero_run;
    logic [DIGITS-1:0]   w_blank;
    logic [3:0]          w_nib;
    logic [SEG_W-1:0]    w_glyph;

    assign w_tick     = (r_cnt == CNT_LAST);
    assign w_boundary = w_tick && (r_idx == IDX_LAST);

    // With no dead time every cycle of the slot drives its digit
    if (DEAD == 0) begin : g_no_dead
        assign w_live = 1'b1;
    end else begin : g_dead
        assign w_live = (r_cnt >= CNT_W'(DEAD));
    end

    // Prescaler and digit index: idx advances once per slot and wraps after the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Double buffer: act only changes on a frame boundary; a load on the boundary bypasses pend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act    <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
        end else if (load) begin
            r_pend <= value;
            if (w_boundary) begin
                r_act    <= value;
                r_pend_v <= 1'b0;
            end else begin
                r_pend_v <= 1'b1;
            end
        end else if (w_boundary && r_pend_v) begin
            r_act    <= r_pend;
            r_pend_v <= 1'b0;
        end
    end

    // Leading-zero mask: a digit is blanked while every nibble from the top down to it is zero
    always_comb begin
        w_blank    = '0;
        w_zero_run = blank_lz;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run & (r_act[4*k +: 4] == 4'h0);
            w_blank[k] = w_zero_run;
        end
    end

    assign w_nib = r_act[{r_idx, 2'b00} +: 4];

    seg7_hex_decode u_decode (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    // Registered pin drivers, one cycle behind the scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dig_en     <= '0;
            r_seg        <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_dig_en     <= w_live ? (DIGITS'(1) << r_idx) : '0;
            r_seg        <= w_blank[r_idx] ? SEG_OFF : w_glyph;
            r_frame_done <= w_boundary;
        end
    end

    assign dig_en     = r_dig_en;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - self-checking bench for seg7_scan_mux
module tb_seg7_scan_mux;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int DEAD     = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  dig_en;
    logic [6:0]  seg;
    logic        frame_done;
    logic [7:0]  dig_en8;
    logic [6:0]  seg8;
    logic        frame_done8;

    always #5 clk = ~clk;

    seg7_scan_mux #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .DEAD(DEAD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .dig_en     (dig_en),
        .seg        (seg),
        .frame_done (frame_done)
    );

    seg7_scan_mux #(.DIGITS(8), .PRESCALE(2), .DEAD(0)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (1'b0),
        .value      (32'h0),
        .blank_lz   (1'b0),
        .dig_en     (dig_en8),
        .seg        (seg8),
        .frame_done (frame_done8)
    );

    typedef struct {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       fd;
        bit         seg_care;
        logic [7:0] dig8;
        logic [6:0] seg8;
        logic       fd8;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    int          m_cnt, m_idx, m8_pos;
    logic [15:0] m_act, m_pend;
    bit          m_pv;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E; 4'h1: return 7'h30; 4'h2: return 7'h6D; 4'h3: return 7'h79;
            4'h4: return 7'h33; 4'h5: return 7'h5B; 4'h6: return 7'h5F; 4'h7: return 7'h70;
            4'h8: return 7'h7F; 4'h9: return 7'h7B; 4'hA: return 7'h77; 4'hB: return 7'h1F;
            4'hC: return 7'h4E; 4'hD: return 7'h3D; 4'hE: return 7'h4F; default: return 7'h47;
        endcase
    endfunction

    function automatic logic [31:0] frame4(input logic [6:0] d3, input logic [6:0] d2,
                                          input logic [6:0] d1, input logic [6:0] d0);
        return {4'h0, d3, d2, d1, d0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs from pre-edge model state, then compare #1 after the edge
    task automatic step();
        exp_t        e;
        logic [3:0]  nib;
        bit          bnd;
        @(posedge clk);
        if (!rst_n) begin
            e.dig = '0; e.seg = '0; e.fd = 1'b0; e.seg_care = 1'b1;
            e.dig8 = '0; e.seg8 = '0; e.fd8 = 1'b0;
            m_cnt = 0; m_idx = 0; m_act = '0; m_pend = '0; m_pv = 0; m8_pos = 0;
        end else begin
            e.dig      = (m_cnt >= DEAD) ? 4'(1 << m_idx) : 4'h0;
            e.seg_care = (e.dig != 4'h0);
            nib        = 4'((m_act >> (4 * m_idx)) & 16'hF);
            e.seg      = (blank_lz && m_idx > 0 && (m_act >> (4 * m_idx)) == 16'h0) ? 7'h00 : glyph(nib);
            bnd        = (m_cnt == PRESCALE - 1) && (m_idx == DIGITS - 1);
            e.fd       = bnd;
            if (load) begin
                if (bnd) begin m_act = value; m_pv = 0; end
                else begin m_pend = value; m_pv = 1; end
            end else if (bnd && m_pv) begin
                m_act = m_pend; m_pv = 0;
            end
            m_cnt = (m_cnt + 1) % PRESCALE;
            if (m_cnt == 0) m_idx = (m_idx + 1) % DIGITS;
            e.dig8 = 8'(1 << ((m8_pos / 2) % 8));
            e.seg8 = 7'h7E;
            e.fd8  = ((m8_pos % 16) == 15);
            m8_pos++;
        end
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk("dig_en", 32'(dig_en), 32'(e.dig));
        if (e.seg_care) chk("seg", 32'(seg), 32'(e.seg));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("dig_en8", 32'(dig_en8), 32'(e.dig8));
        chk("seg8", 32'(seg8), 32'(e.seg8));
        chk("frame_done8", 32'(frame_done8), 32'(e.fd8));
    endtask

    // Run one frame starting right after a boundary; optional loads before steps la and lb
    task automatic run_frame(input int la, input logic [15:0] va, input int lb, input logic [15:0] vb,
                             output logic [31:0] segs);
        segs = '0;
        for (int j = 1; j <= 16; j++) begin
            if (j == la) begin load = 1'b1; value = va; end
            else if (j == lb) begin load = 1'b1; value = vb; end
            else load = 1'b0;
            step();
            if (j % 4 == 0) segs[7 * (j / 4 - 1) +: 7] = seg;
        end
        load = 1'b0;
        chk("frame_end_pulse", 32'(frame_done), 32'h1);
    endtask

    initial begin
        logic [31:0] s;
        rst_n = 1'b0; load = 1'b0; value = '0; blank_lz = 1'b0;
        m_cnt = 0; m_idx = 0; m_act = '0; m_pend = '0; m_pv = 0; m8_pos = 0;

        // Reset held, with a load that must be ignored
        load = 1'b1; value = 16'hFFFF;
        for (int i = 0; i < 5; i++) step();
        load = 1'b0;
        chk("reset_dig_en", 32'(dig_en), 32'h0);
        chk("reset_seg", 32'(seg), 32'h0);

        // Release and first frame
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 1) chk("first_off", 32'(dig_en), 32'h0);
            if (i == 2) chk("first_on", 32'(dig_en), 32'h1);
            if (i == 6) chk("slot1", 32'(dig_en), 32'h2);
            if (i == 10) chk("slot2", 32'(dig_en), 32'h4);
            if (i == 14) chk("slot3", 32'(dig_en), 32'h8);
        end
        chk("first_frame_done", 32'(frame_done), 32'h1);
        run_frame(0, '0, 0, '0, s);
        chk("frame_zero", s, frame4(7'h7E, 7'h7E, 7'h7E, 7'h7E));

        // Double buffering: mid-frame load does not disturb the current frame
        run_frame(10, 16'h1A2F, 0, '0, s);
        chk("dbuf_hold", s, frame4(7'h7E, 7'h7E, 7'h7E, 7'h7E));
        run_frame(0, '0, 0, '0, s);
        chk("dbuf_show", s, frame4(7'h30, 7'h77, 7'h6D, 7'h47));

        // Leading-zero blanking
        blank_lz = 1'b1;
        run_frame(5, 16'h0030, 0, '0, s);
        chk("lz_none", s, frame4(7'h30, 7'h77, 7'h6D, 7'h47));
        run_frame(5, 16'h0000, 0, '0, s);
        chk("lz_0030", s, frame4(7'h00, 7'h00, 7'h79, 7'h7E));
        run_frame(5, 16'h0300, 0, '0, s);
        chk("lz_0000", s, frame4(7'h00, 7'h00, 7'h00, 7'h7E));
        run_frame(0, '0, 0, '0, s);
        chk("lz_0300", s, frame4(7'h00, 7'h79, 7'h7E, 7'h7E));
        blank_lz = 1'b0;

        // Load on the boundary beats an older pending value
        run_frame(7, 16'h1111, 16, 16'h9999, s);
        chk("bnd_prev", s, frame4(7'h7E, 7'h79, 7'h7E, 7'h7E));
        run_frame(0, '0, 0, '0, s);
        chk("bnd_9999", s, frame4(7'h7B, 7'h7B, 7'h7B, 7'h7B));
        run_frame(0, '0, 0, '0, s);
        chk("bnd_pend_cleared", s, frame4(7'h7B, 7'h7B, 7'h7B, 7'h7B));

        // Two loads in one frame: last wins
        run_frame(3, 16'h1234, 9, 16'h5678, s);
        chk("two_load_hold", s, frame4(7'h7B, 7'h7B, 7'h7B, 7'h7B));
        run_frame(0, '0, 0, '0, s);
        chk("two_load_last", s, frame4(7'h5B, 7'h5F, 7'h70, 7'h7F));

        // Asynchronous reset at idx=2, cnt=3
        for (int i = 0; i < 11; i++) step();
        chk("pre_reset_slot", 32'(dig_en), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_dig_en", 32'(dig_en), 32'h0);
        chk("async_seg", 32'(seg), 32'h0);
        chk("async_dig_en8", 32'(dig_en8), 32'h0);
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 1) chk("restart_off", 32'(dig_en), 32'h0);
            if (i == 2) chk("restart_digit0", 32'(dig_en), 32'h1);
        end
        run_frame(0, '0, 0, '0, s);
        chk("restart_act_zero", s, frame4(7'h7E, 7'h7E, 7'h7E, 7'h7E));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
